// File: rtl/pe_alu_pkg.sv
// Shared opcode, FSM and timing definitions for the PE execute stage.
// Imported by the ALU stage and the iterative multiplier.
package pe_alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLL    = 4'd2;
  localparam logic [3:0] OP_SLT    = 4'd3;
  localparam logic [3:0] OP_SLTU   = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_MUL    = 4'd10;
  localparam logic [3:0] OP_MULH   = 4'd11;
  localparam logic [3:0] OP_MULHSU = 4'd12;
  localparam logic [3:0] OP_MULHU  = 4'd13;
  localparam logic [3:0] OP_PASSA  = 4'd14;
  localparam logic [3:0] OP_PASSB  = 4'd15;

  localparam int MUL_CYCLES = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

endpackage

// File: rtl/pe_iter_mul.sv
// Radix-2 shift-add multiplier on operand magnitudes.
// The sign fix is folded into the product presented on the done cycle.
module pe_iter_mul
  import pe_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  input  logic        neg,
  output logic        done,
  output logic [63:0] prod
);

  localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

  logic        run_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        neg_q;
  logic [63:0] sum_w;

  assign sum_w = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign done  = run_q && (cnt_q == CNT_LAST);
  assign prod  = neg_q ? (~sum_w + 64'd1) : sum_w;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {32'd0, a_mag};
      mplier_q <= b_mag;
      neg_q    <= neg;
    end else if (run_q) begin
      acc_q    <= sum_w;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_alu_stage.sv
// PE execute stage: single-cycle RV32I ALU plus iterative RV32M
// multiply, valid/ready on both sides, registered result bus.
module pe_alu_stage
  import pe_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a_op,
  input  logic [XLEN-1:0] b_op,
  input  logic [3:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            hi_q;

  logic            accept;
  logic            is_mul;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            a_sgn;
  logic            b_sgn;
  logic [31:0]     a_mag;
  logic [31:0]     b_mag;
  logic            mul_done;
  logic [63:0]     mul_prod;

  assign in_ready  = (state_q == ST_IDLE) &&
                     (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && is_mul_op(alu_op);
  assign shamt     = b_op[4:0];
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q == ST_MUL);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:   alu_res = a_op + b_op;
      OP_SUB:   alu_res = a_op - b_op;
      OP_SLL:   alu_res = a_op << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}},
                           $signed(a_op) < $signed(b_op)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, a_op < b_op};
      OP_XOR:   alu_res = a_op ^ b_op;
      OP_SRL:   alu_res = a_op >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(a_op) >>> shamt);
      OP_OR:    alu_res = a_op | b_op;
      OP_AND:   alu_res = a_op & b_op;
      OP_PASSA: alu_res = a_op;
      OP_PASSB: alu_res = b_op;
      default:  alu_res = '0;
    endcase
  end

  // MULH signs both operands, MULHSU only A; MUL low half is sign-agnostic
  assign a_sgn = ((alu_op == OP_MULH) || (alu_op == OP_MULHSU)) &&
                 a_op[31];
  assign b_sgn = (alu_op == OP_MULH) && b_op[31];
  assign a_mag = a_sgn ? (~a_op + 32'd1) : a_op;
  assign b_mag = b_sgn ? (~b_op + 32'd1) : b_op;

  pe_iter_mul u_mul (
    .clk   (clk),
    .reset (reset),
    .start (accept && is_mul),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .neg   (a_sgn ^ b_sgn),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_valid_q && out_ready) out_valid_q <= 1'b0;
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL;
              hi_q    <= (alu_op != OP_MUL);
            end else begin
              result_q    <= alu_res;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q    <= hi_q ? mul_prod[63:32] : mul_prod[31:0];
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_alu_stage.sv
// Directed bench for pe_alu_stage: ALU table, multiply timing,
// backpressure and reset during a multiply.
module tb_pe_alu_stage;
  import pe_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_op;
  logic [31:0] b_op;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_alu_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_op      (a_op),
    .b_op      (b_op),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  localparam int NV = 15;
  logic [3:0]  v_op [NV] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU,
                             OP_SRA, OP_SRL, OP_SLL, OP_XOR,
                             OP_OR, OP_AND, OP_PASSA, OP_PASSB,
                             OP_ADD, OP_SLT, OP_SLTU};
  logic [31:0] v_a [NV] = '{32'h5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'h80000000, 32'h3,
                            32'hF0F0F0F0, 32'h0F000000, 32'hFF00FF00,
                            32'h12345678, 32'h1, 32'hFFFFFFFF,
                            32'h1, 32'h1};
  logic [31:0] v_b [NV] = '{32'h7, 32'h1, 32'h1, 32'h1,
                            32'h24, 32'h24, 32'h21,
                            32'h0FF00FF0, 32'h000000F0, 32'h0FF00FF0,
                            32'h9, 32'hCAFEBABE, 32'h2,
                            32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_e [NV] = '{32'd12, 32'hFFFFFFFF, 32'h1, 32'h0,
                            32'hF8000000, 32'h08000000, 32'h6,
                            32'hFF00FF00, 32'h0F0000F0, 32'h0F000F00,
                            32'h12345678, 32'hCAFEBABE, 32'h1,
                            32'h0, 32'h1};

  task automatic run_mul(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int bad;
    bad = 0;
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = op;
    a_op     = a;
    b_op     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    // samples after acceptance edge through 31 edges later
    for (int c = 1; c <= 32; c++) begin
      if (!(busy === 1'b1 && in_ready === 1'b0 &&
            out_valid === 1'b0)) bad++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_window"}, bad, 0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int bad;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_op      = '0;
    b_op      = '0;
    alu_op    = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b_valid%0d", i - 1), {31'd0, out_valid}, 32'd1);
        chk($sformatf("b2b_res%0d", i - 1), result, v_e[i-1]);
      end else begin
        chk("pre_valid", {31'd0, out_valid}, 32'd0);
      end
      chk($sformatf("b2b_ready%0d", i), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      alu_op   = v_op[i];
      a_op     = v_a[i];
      b_op     = v_b[i];
    end
    @(negedge clk);
    chk("b2b_valid_last", {31'd0, out_valid}, 32'd1);
    chk("b2b_res_last", result, v_e[NV-1]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    run_mul("mul", OP_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001);
    run_mul("mulh", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    run_mul("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mul("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_mul("mul_neg", OP_MUL, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    @(posedge clk);
    #1 chk("mul_drain", {31'd0, out_valid}, 32'd0);

    // backpressure: result held, new op offered but ignored
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = OP_ADD;
    a_op      = 32'd100;
    b_op      = 32'd23;
    @(posedge clk);
    #1;
    alu_op = OP_PASSA;
    a_op   = 32'h0000DEAD;
    bad    = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && result === 32'd123 &&
            in_ready === 1'b0)) bad++;
    end
    chk("bp_hold", bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_swap_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_swap_res", result, 32'h0000DEAD);
    @(posedge clk);
    #1 chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // reset at cycle 10 of a multiply
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = OP_MUL;
    a_op     = 32'd3;
    b_op     = 32'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    bad   = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) bad++;
    end
    chk("mrst_no_late", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
